btn_debounce: RTL and testbench

Input-side counterpart to the board LED drivers. Samples the push-buttons on the 125 MHz fabric clock and synchronises them. It then debounces each channel independently. Outputs per channel:
- a clean level,
- single-cycle press and release pulses,
- a press-toggled latch, which can drive the 4 LEDs directly or feed control logic.

---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_debounce_if.sv | 39 +++
 rtl/btn_debounce_ch.sv | 77 +++++++
 rtl/btn_debounce.sv | 53 +++++
 tb/tb_btn_debounce.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared constants, per-channel output bundle and counter sizing for the button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

    localparam int CLK_HZ            = 125_000_000;
    localparam int DEBOUNCE_MS       = 10;
    localparam int DB_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // One debounced channel's registered outputs.
    // The release field is named rel because "release" is a reserved word.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic toggle;
    } btn_ch_t;

    // Smallest counter width that can hold db_cycles, so that 2**width > db_cycles.
    function automatic int cnt_width(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: raw pins in, debounced level, press/release pulses and toggle latch out.
// Latency: n/a (wiring only).
// Backpressure: none; every output is a free-running registered level or a single-cycle pulse.
//
// Ports:
//   btn          raw asynchronous pins, 1 = pressed
//   btn_level    debounced stable level
//   btn_press    one-cycle pulse on an accepted 0->1 transition
//   btn_release  one-cycle pulse on an accepted 1->0 transition
//   btn_toggle   latch that flips on every accepted press
//
// Modports: master is the board/consumer side, slave is the debouncer.
interface btn_debounce_if #(
    parameter int N_BTN = 4
);

    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_toggle;

    modport master (
        output btn,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_toggle
    );

    modport slave (
        input  btn,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_toggle
    );

endinterface

// File: rtl/btn_debounce_ch.sv
// Debounces one button: synchroniser chain, qualification counter, level, press/release pulses and toggle.
// Latency: pin to level is SYNC_STAGES + DB_CYCLES cycles, plus one cycle of sampling uncertainty.
// Backpressure: none; the pulses last exactly one cycle and are never held.
//
// Ports:
//   sysclk  fabric clock
//   rst     synchronous, active-high reset
//   btn     raw asynchronous pin
//   ch_out  registered level, press, release and toggle
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int CNT_W       = cnt_width(DB_CYCLES),
    parameter int SYNC_STAGES = 2
) (
    input  logic    sysclk,
    input  logic    rst,
    input  logic    btn,
    output btn_ch_t ch_out
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   rel_q;
    logic                   toggle_q;

    // Plain shift chain. Stage 0 may go metastable; only the last stage is used.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // The counter only runs while s disagrees with the accepted level. Any return
    // to agreement clears it, so a bounce train gets no partial credit. The
    // counter tops out at DB_LAST, so it never wraps.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q    <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            if (s == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                // Accept the change. The pulse and toggle land on the same edge as the level.
                cnt_q    <= '0;
                level_q  <= s;
                press_q  <= s;
                rel_q    <= ~s;
                toggle_q <= toggle_q ^ s;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ch_out.level  = level_q;
    assign ch_out.press  = press_q;
    assign ch_out.rel    = rel_q;
    assign ch_out.toggle = toggle_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces N_BTN independent push-buttons into clean levels, press/release pulses and press-toggled latches.
// Latency: pin to level is SYNC_STAGES + DB_CYCLES cycles (+1 sampling uncertainty); pulses coincide with the level change.
// Backpressure: none; outputs are registered and the pulses are single-cycle.
//
// Ports:
//   sysclk  125 MHz fabric clock
//   rst     synchronous, active-high reset
//   bus     btn_debounce_if slave: btn in; btn_level, btn_press, btn_release, btn_toggle out
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int CNT_W       = cnt_width(DB_CYCLES),
    parameter int SYNC_STAGES = 2
) (
    input logic            sysclk,
    input logic            rst,
    btn_debounce_if.slave  bus
);

    // Reject parameter sets that would wrap the counter or weaken the synchroniser.
    if (DB_CYCLES < 1) begin : g_bad_db
        $error("btn_debounce: DB_CYCLES must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_cnt_w
        $error("btn_debounce: CNT_W too small, need 2**CNT_W > DB_CYCLES");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce: SYNC_STAGES must be at least 2");
    end

    btn_ch_t ch_out [N_BTN];

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .sysclk (sysclk),
            .rst    (rst),
            .btn    (bus.btn[i]),
            .ch_out (ch_out[i])
        );

        assign bus.btn_level[i]   = ch_out[i].level;
        assign bus.btn_press[i]   = ch_out[i].press;
        assign bus.btn_release[i] = ch_out[i].rel;
        assign bus.btn_toggle[i]  = ch_out[i].toggle;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with DB_CYCLES=8 and SYNC_STAGES=2.
// Latency: inputs are driven on the falling edge, so every pulse is expected exactly SYNC + DB cycles after its driving edge.
// Backpressure: n/a.
module tb_btn_debounce;

    localparam int N   = 4;
    localparam int DB  = 8;
    localparam int SYN = 2;
    localparam int LAT = SYN + DB;

    typedef struct {
        int ch;
        bit press;
        int cyc;
        bit toggle;
    } ev_t;

    logic sysclk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;
    bit   mon_en;
    ev_t  sb[$];

    btn_debounce_if #(.N_BTN(N)) dif ();

    btn_debounce #(
        .N_BTN       (N),
        .DB_CYCLES   (DB),
        .CNT_W       (4),
        .SYNC_STAGES (SYN)
    ) dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (dif)
    );

    initial sysclk = 1'b0;
    always #4 sysclk = ~sysclk;

    always @(posedge sysclk) cyc = cyc + 1;

    // Every pulse must match the oldest expected event: same channel, kind,
    // cycle, level and toggle. A pulse with nothing expected is a failure.
    always @(negedge sysclk) begin
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                if (dif.btn_press[i] === 1'b1 || dif.btn_release[i] === 1'b1) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse ch=%0d cyc=%0d press=%b release=%b (none expected)",
                                 i, cyc, dif.btn_press[i], dif.btn_release[i]);
                    end else begin
                        ev_t ev;
                        ev = sb.pop_front();
                        if (ev.ch !== i || ev.cyc !== cyc ||
                            dif.btn_press[i] !== ev.press || dif.btn_release[i] !== !ev.press ||
                            dif.btn_level[i] !== ev.press || dif.btn_toggle[i] !== ev.toggle) begin
                            errors++;
                            $display("FAIL pulse_event got ch=%0d cyc=%0d p=%b r=%b lvl=%b tog=%b want ch=%0d cyc=%0d p=%b r=%b lvl=%b tog=%b",
                                     i, cyc, dif.btn_press[i], dif.btn_release[i], dif.btn_level[i], dif.btn_toggle[i],
                                     ev.ch, ev.cyc, ev.press, !ev.press, ev.press, ev.toggle);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic expect_ev(input int ch, input bit press, input bit tog);
        sb.push_back('{ch, press, cyc + LAT, tog});
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        dif.btn = '0;
        tick(3);
        checks += 4;
        if (dif.btn_level   !== 4'b0) begin errors++; $display("FAIL reset_level got=%b want=0000", dif.btn_level); end
        if (dif.btn_press   !== 4'b0) begin errors++; $display("FAIL reset_press got=%b want=0000", dif.btn_press); end
        if (dif.btn_release !== 4'b0) begin errors++; $display("FAIL reset_release got=%b want=0000", dif.btn_release); end
        if (dif.btn_toggle  !== 4'b0) begin errors++; $display("FAIL reset_toggle got=%b want=0000", dif.btn_toggle); end
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(100);
        checks += 2;
        if (dif.btn_level  !== 4'b0) begin errors++; $display("FAIL idle_level got=%b want=0000", dif.btn_level); end
        if (dif.btn_toggle !== 4'b0) begin errors++; $display("FAIL idle_toggle got=%b want=0000", dif.btn_toggle); end
    endtask

    task automatic test_drain(input string name);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_pulse got=%0d outstanding want=0 (first ch=%0d cyc=%0d)",
                     name, sb.size(), sb[0].ch, sb[0].cyc);
            sb.delete();
        end
    endtask

    task automatic test_state(input string name, input logic [N-1:0] lvl, input logic [N-1:0] tog);
        checks += 2;
        if (dif.btn_level !== lvl) begin
            errors++;
            $display("FAIL %s_level got=%b want=%b", name, dif.btn_level, lvl);
        end
        if (dif.btn_toggle !== tog) begin
            errors++;
            $display("FAIL %s_toggle got=%b want=%b", name, dif.btn_toggle, tog);
        end
    endtask

    task automatic test_clean_press();
        dif.btn[0] = 1'b1;
        expect_ev(0, 1'b1, 1'b1);
        // One cycle short of acceptance the level must still read 0.
        tick(LAT - 1);
        checks++;
        if (dif.btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL clean_early_level got=%b want=0", dif.btn_level[0]);
        end
        tick(11);
        test_drain("clean");
        test_state("clean", 4'b0001, 4'b0001);
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 5; k++) begin
            dif.btn[1] = ~dif.btn[1];
            if (k == 4) expect_ev(1, 1'b1, 1'b1);
            tick(3);
        end
        tick(15);
        test_drain("bounce");
        test_state("bounce", 4'b0011, 4'b0011);
    endtask

    task automatic test_glitch();
        dif.btn[2] = 1'b1;
        tick(DB - 1);
        dif.btn[2] = 1'b0;
        tick(20);
        test_drain("glitch");
        test_state("glitch", 4'b0011, 4'b0011);
    endtask

    task automatic test_release_toggle();
        for (int r = 0; r < 2; r++) begin
            dif.btn[3] = 1'b1;
            expect_ev(3, 1'b1, (r == 0));
            tick(20);
            checks++;
            if (dif.btn_toggle[3] !== (r == 0)) begin
                errors++;
                $display("FAIL toggle_after_press%0d got=%b want=%b", r, dif.btn_toggle[3], (r == 0));
            end
            dif.btn[3] = 1'b0;
            expect_ev(3, 1'b0, (r == 0));
            tick(20);
        end
        test_drain("reltog");
        test_state("reltog", 4'b0011, 4'b0011);
    endtask

    task automatic test_reset_mid_debounce();
        dif.btn[0] = 1'b0;
        expect_ev(0, 1'b0, 1'b1);
        tick(15);
        test_drain("rst_prelude");
        dif.btn[0] = 1'b1;
        tick(6);
        rst = 1'b1;
        tick(1);
        test_state("rst_mid", 4'b0000, 4'b0000);
        rst = 1'b0;
        // Channel 1 is still held, so both channels re-accept on the same cycle.
        expect_ev(0, 1'b1, 1'b1);
        expect_ev(1, 1'b1, 1'b1);
        tick(15);
        test_drain("rst_mid");
        test_state("rst_after", 4'b0011, 4'b0011);
    endtask

    initial begin
        cyc    = 0;
        errors = 0;
        checks = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_toggle();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d want=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
